// File: rtl/apb_mem_slave.sv
// APB3 memory slave: byte-strobed word memory with configurable wait states.
// Define APB_SLVERR_EN to enable pslverr on misaligned or out-of-range accesses.
module apb_mem_slave #(
  parameter int addr_width  = 32,
  parameter int data_width  = 32,
  parameter int depth       = 64,
  parameter int wait_states = 0
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [addr_width-1:0]   paddr,
  input  logic                    pselx,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [data_width-1:0]   pwdata,
  input  logic [data_width/8-1:0] pstrb,
  output logic [data_width-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int NB    = data_width / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = $clog2(depth);
  localparam logic [3:0] WS = 4'(wait_states);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e                state_q;
  logic [3:0]            wcnt_q;
  logic [addr_width-1:0] addr_q;
  logic                  write_q;
  logic [data_width-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [data_width-1:0] mem_q [depth];

  logic [IDX_W-1:0] idx;
  logic             err;
  logic             rdy;

  // Slicing the word index out of the address wraps modulo depth for free;
  // out-of-range detection, when enabled, looks at the full shifted address.
  assign idx = addr_q[LSB +: IDX_W];

`ifdef APB_SLVERR_EN
  localparam logic [addr_width-1:0] LOW_MASK = addr_width'((1 << LSB) - 1);
  localparam logic [addr_width-1:0] DEPTH_A  = addr_width'(depth);

  assign err = ((addr_q >> LSB) >= DEPTH_A) || ((addr_q & LOW_MASK) != '0);
`else
  logic unused_addr;

  assign err         = 1'b0;
  assign unused_addr = ^addr_q;
`endif

  assign rdy     = (state_q == ACCESS) && (wcnt_q == WS);
  assign pready  = rdy;
  assign pslverr = rdy && err;
  assign prdata  = (rdy && !write_q && !err) ? mem_q[idx] : '0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      for (int unsigned i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (pselx && !penable) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            wcnt_q  <= '0;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (pselx && penable) begin
            if (rdy) begin
              state_q <= IDLE;
              if (write_q && !err) begin
                for (int unsigned b = 0; b < NB; b++) begin
                  if (strb_q[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                  end
                end
              end
            end else begin
              wcnt_q <= wcnt_q + 4'd1;
            end
          end else begin
            // Protocol abort: master dropped select or enable mid-transfer.
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: three instances (0, 3 and 2 wait states)
// sharing one APB bus, selected individually by psel.
module tb_apb_mem_slave;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [31:0] paddr = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  psel = '0;

  logic [31:0] prdata_w [3];
  logic        pready_w [3];
  logic        pslverr_w [3];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

`ifdef APB_SLVERR_EN
  localparam logic SLV_EN = 1'b1;
`else
  localparam logic SLV_EN = 1'b0;
`endif

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  apb_mem_slave #(.addr_width(32), .data_width(32), .depth(64), .wait_states(0)) u_ws0 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pselx(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_w[0]),
    .pready(pready_w[0]), .pslverr(pslverr_w[0])
  );

  apb_mem_slave #(.addr_width(32), .data_width(32), .depth(64), .wait_states(3)) u_ws3 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pselx(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_w[1]),
    .pready(pready_w[1]), .pslverr(pslverr_w[1])
  );

  apb_mem_slave #(.addr_width(32), .data_width(32), .depth(64), .wait_states(2)) u_ws2 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pselx(psel[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_w[2]),
    .pready(pready_w[2]), .pslverr(pslverr_w[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete transfer; returns data/error sampled on the pready cycle,
  // the number of pready-low access cycles, total cycles, and whether prdata
  // was ever nonzero while pready was low.
  task automatic xfer(input int d, input logic [31:0] a, input logic wr,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic er, output int waits,
                      output int cycles, output logic leak);
    int unsigned c0;
    @(negedge pclk);
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    paddr   = a;
    pwrite  = wr;
    pwdata  = wd;
    pstrb   = st;
    c0      = cyc;
    @(negedge pclk);
    penable = 1'b1;
    waits   = 0;
    leak    = 1'b0;
    #1;
    while (!pready_w[d] && waits < 40) begin
      if (prdata_w[d] != '0) leak = 1'b1;
      @(negedge pclk);
      #1;
      waits++;
    end
    rd = prdata_w[d];
    er = pslverr_w[d];
    @(posedge pclk);
    #1;
    cycles = int'(cyc - c0);
  endtask

  logic [31:0] rd;
  logic        er, lk, seen;
  int          w, c, c2;

  initial begin
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    #1;
    for (int unsigned i = 0; i < 3; i++) begin
      check("rst_pready", 32'(pready_w[i]), 32'd0);
      check("rst_pslverr", 32'(pslverr_w[i]), 32'd0);
      check("rst_prdata", prdata_w[i], 32'd0);
    end

    // Basic write then back-to-back read, zero wait states
    xfer(0, 32'h08, 1'b1, 32'hDEADBEEF, 4'hF, rd, er, w, c, lk);
    check("wr08_err", 32'(er), 32'd0);
    check("wr08_prdata", rd, 32'd0);
    check("wr08_cycles", c, 2);
    xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, rd, er, w, c2, lk);
    check("rd08_data", rd, 32'hDEADBEEF);
    check("rd08_err", 32'(er), 32'd0);
    check("b2b_cycles", c + c2, 4);

    // Partial strobe write
    xfer(0, 32'h10, 1'b1, 32'h11223344, 4'h5, rd, er, w, c, lk);
    xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, rd, er, w, c, lk);
    check("strb5_data", rd, 32'h00220044);

    // Zero strobe leaves word untouched, no error
    xfer(0, 32'h08, 1'b1, 32'hFFFFFFFF, 4'h0, rd, er, w, c, lk);
    check("strb0_err", 32'(er), 32'd0);
    xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, rd, er, w, c, lk);
    check("strb0_data", rd, 32'hDEADBEEF);

    // penable high while idle must not start a transfer
    @(negedge pclk);
    psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h08;
    pwdata = 32'h0; pstrb = 4'hF;
    seen = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge pclk);
      #1;
      if (pready_w[0]) seen = 1'b1;
    end
    check("idle_en_pready", 32'(seen), 32'd0);
    xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, rd, er, w, c, lk);
    check("idle_en_data", rd, 32'hDEADBEEF);

    // Out-of-range and misaligned accesses
    xfer(0, 32'h100, 1'b1, 32'hCAFEF00D, 4'hF, rd, er, w, c, lk);
    check("oor_wr_err", 32'(er), 32'(SLV_EN));
    xfer(0, 32'h02, 1'b1, 32'h0BADC0DE, 4'hF, rd, er, w, c, lk);
    check("mis_wr_err", 32'(er), 32'(SLV_EN));
    xfer(0, 32'h00, 1'b0, 32'h0, 4'h0, rd, er, w, c, lk);
    check("word0_data", rd, SLV_EN ? 32'h0 : 32'h0BADC0DE);
    xfer(0, 32'h100, 1'b0, 32'h0, 4'h0, rd, er, w, c, lk);
    check("oor_rd_data", rd, SLV_EN ? 32'h0 : 32'h0BADC0DE);
    check("oor_rd_err", 32'(er), 32'(SLV_EN));
    xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, rd, er, w, c, lk);
    check("word2_kept", rd, 32'hDEADBEEF);

    // Three wait states
    xfer(1, 32'h04, 1'b1, 32'h55AA55AA, 4'hF, rd, er, w, c, lk);
    check("ws3_wr_waits", w, 3);
    check("ws3_wr_cycles", c, 5);
    xfer(1, 32'h04, 1'b0, 32'h0, 4'h0, rd, er, w, c, lk);
    check("ws3_rd_waits", w, 3);
    check("ws3_rd_data", rd, 32'h55AA55AA);
    check("ws3_rd_leak", 32'(lk), 32'd0);
    check("ws3_rd_cycles", c, 5);

    // Abort after one access cycle with two wait states
    xfer(2, 32'h08, 1'b1, 32'h13572468, 4'hF, rd, er, w, c, lk);
    check("ws2_wr_waits", w, 2);
    @(negedge pclk);
    psel = 3'b100; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1;
    pwdata = 32'hFFFF0000; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    penable = 1'b0;
    @(negedge pclk);
    psel = 3'b000;
    #1;
    check("abort_pready", 32'(pready_w[2]), 32'd0);
    check("abort_pslverr", 32'(pslverr_w[2]), 32'd0);
    xfer(2, 32'h08, 1'b0, 32'h0, 4'h0, rd, er, w, c, lk);
    check("abort_data", rd, 32'h13572468);
    check("abort_next_waits", w, 2);

    // Reset during the access phase of a write
    xfer(0, 32'h0C, 1'b1, 32'hAAAA5555, 4'hF, rd, er, w, c, lk);
    @(negedge pclk);
    psel = 3'b001; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    preset  = 1'b1;
    @(negedge pclk);
    preset  = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    #1;
    check("midrst_pready", 32'(pready_w[0]), 32'd0);
    check("midrst_pslverr", 32'(pslverr_w[0]), 32'd0);
    check("midrst_prdata", prdata_w[0], 32'd0);
    xfer(0, 32'h0C, 1'b0, 32'h0, 4'h0, rd, er, w, c, lk);
    check("midrst_word", rd, 32'h0);
    xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, rd, er, w, c, lk);
    check("midrst_cleared", rd, 32'h0);

    @(negedge pclk);
    psel = '0;
    penable = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
